// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the synchronous-read Data-Memory between CPU and UART loader
module dmem_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_stall,
  output logic              cpu_err,
  input  logic              upg_req,
  input  logic              upg_we,
  input  logic [ADDR_W-1:0] upg_addr,
  input  logic [31:0]       upg_wdata,
  output logic [31:0]       upg_rdata,
  output logic              upg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              owner
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        r_state;
  logic              r_owner, r_we, r_err, r_cpu_ready, r_upg_ack, r_cpu_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_cpu_rdata, r_upg_rdata;
  logic              w_cpu_elig, w_upg_elig, w_gnt_upg, w_grant, w_cpu_bad;
  logic [ADDR_W-1:0] w_cpu_waddr;

  // A requester whose completion pulse is high this cycle sits out, so the other side wins the slot
  assign w_cpu_elig  = cpu_req & ~r_cpu_ready;
  assign w_upg_elig  = upg_req & ~r_upg_ack;
  assign w_gnt_upg   = w_upg_elig & (~w_cpu_elig | ~r_owner);
  assign w_grant     = (r_state == S_IDLE) & (w_cpu_elig | w_upg_elig);
  assign w_cpu_waddr = cpu_addr[ADDR_W+1:2];
  assign w_cpu_bad   = (cpu_addr[1:0] != 2'b00) | (cpu_addr[31:ADDR_W+2] != '0);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b1;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_upg_rdata <= '0;
      r_cpu_ready <= 1'b0;
      r_upg_ack   <= 1'b0;
      r_cpu_err   <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_upg_ack   <= 1'b0;
      r_cpu_err   <= 1'b0;
      if (w_grant) begin
        r_state <= S_ISSUE;
        r_owner <= w_gnt_upg;
        r_we    <= w_gnt_upg ? upg_we : cpu_we & ~w_cpu_bad;
        r_addr  <= w_gnt_upg ? upg_addr : w_cpu_waddr;
        r_wdata <= w_gnt_upg ? upg_wdata : cpu_wdata;
        r_err   <= ~w_gnt_upg & w_cpu_bad;
      end else if (r_state == S_ISSUE) begin
        r_state <= S_RESP;
      end else if (r_state == S_RESP) begin
        r_state <= S_IDLE;
        if (r_owner) begin
          r_upg_rdata <= mem_rdata;
          r_upg_ack   <= 1'b1;
        end else begin
          r_cpu_rdata <= r_err ? '0 : mem_rdata;
          r_cpu_ready <= 1'b1;
          r_cpu_err   <= r_err;
        end
      end else begin
        r_state <= S_IDLE;
      end
    end

  // Write strobe is gated by state so an asynchronous reset kills it immediately
  assign mem_we    = (r_state == S_ISSUE) & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign cpu_err   = r_cpu_err;
  assign cpu_stall = cpu_req & ~r_cpu_ready;
  assign upg_rdata = r_upg_rdata;
  assign upg_ack   = r_upg_ack;
  assign owner     = r_owner;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level memory model
module tb_dmem_arbiter;
  localparam int AW = 14;
  logic          clk, rst;
  logic          cpu_req, cpu_we, cpu_ready, cpu_stall, cpu_err;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          upg_req, upg_we, upg_ack;
  logic [AW-1:0] upg_addr, mem_addr;
  logic [31:0]   upg_wdata, upg_rdata, mem_wdata, mem_rdata;
  logic          mem_we, owner;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;
  logic [31:0]   ram [0:(1<<AW)-1];
  logic [31:0]   shadow [16];
  int            n_cmp, n_fail;

  dmem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .upg_req(upg_req), .upg_we(upg_we), .upg_addr(upg_addr), .upg_wdata(upg_wdata),
    .upg_rdata(upg_rdata), .upg_ack(upg_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM with a backdoor preload port
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (bd_we) ram[bd_addr] <= bd_data;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; upg_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; lat = 0;
    do begin tick(); lat++; end while (!cpu_ready && lat < 20);
    rd = cpu_rdata; er = cpu_err; cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b1;
    tick();
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
    n_cmp++; if (upg_rdata !== '0) begin n_fail++; $display("FAIL reset_upg_rdata: got %h want 0", upg_rdata); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready: got %b want 0", cpu_ready); end
    n_cmp++; if (upg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_upg_ack: got %b want 0", upg_ack); end
    n_cmp++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_err: got %b want 0", cpu_err); end
    n_cmp++; if (owner !== 1'b1) begin n_fail++; $display("FAIL reset_owner: got %b want 1", owner); end
    n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_hi: got %b want 1", cpu_stall); end
    cpu_req = 1'b0;
    #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_lo: got %b want 0", cpu_stall); end
    rst = 1'b0;
    tick();
    n_cmp++; if (mem_we !== 1'b0 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got we=%b rdy=%b want 0 0", mem_we, cpu_ready); end
  endtask

  task automatic test_cpu_load();
    preload(AW'(4), 32'hDEAD_BEEF);
    cpu_we = 1'b0; cpu_addr = 32'h0000_0010; cpu_req = 1'b1;
    #1;
    n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_c0: got %b want 1", cpu_stall); end
    tick();
    n_cmp++; if (mem_addr !== AW'(4)) begin n_fail++; $display("FAIL load_mem_addr: got %h want 4", mem_addr); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL load_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (owner !== 1'b0) begin n_fail++; $display("FAIL load_owner: got %b want 0", owner); end
    n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_c1: got %b want 1", cpu_stall); end
    tick();
    n_cmp++; if (cpu_stall !== 1'b1 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL load_c2: got stall=%b rdy=%b want 1 0", cpu_stall, cpu_ready); end
    tick();
    n_cmp++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_c3: got %b want 1", cpu_ready); end
    n_cmp++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h want deadbeef", cpu_rdata); end
    n_cmp++; if (cpu_stall !== 1'b0 || cpu_err !== 1'b0) begin n_fail++; $display("FAIL load_c3: got stall=%b err=%b want 0 0", cpu_stall, cpu_err); end
    cpu_req = 1'b0;
    tick();
    n_cmp++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_c4: got %b want 0", cpu_ready); end
  endtask

  task automatic test_cpu_store();
    logic [31:0] rd; logic er; int lat;
    cpu_we = 1'b1; cpu_addr = 32'h0000_0008; cpu_wdata = 32'h1234_5678; cpu_req = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL store_we_c0: got %b want 0", mem_we); end
    tick();
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== AW'(2) || mem_wdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL store_issue: got we=%b addr=%h wd=%h want 1 2 12345678", mem_we, mem_addr, mem_wdata); end
    cpu_wdata = 32'hFFFF_0000;
    tick();
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL store_we_c2: got %b want 0", mem_we); end
    tick();
    n_cmp++; if (cpu_ready !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL store_c3: got rdy=%b we=%b want 1 0", cpu_ready, mem_we); end
    cpu_req = 1'b0;
    tick();
    cpu_op(1'b0, 32'h0000_0008, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL store_readback: got %h want 12345678", rd); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL store_readback_lat: got %0d want 3", lat); end
  endtask

  task automatic test_tie();
    logic [31:0] v;
    v = $urandom;
    preload(AW'(7), v);
    preload(AW'(4), 32'hCAFE_F00D);
    do_reset();
    cpu_we = 1'b0; cpu_addr = 32'h0000_0010; cpu_req = 1'b1;
    upg_we = 1'b0; upg_addr = AW'(7); upg_req = 1'b1;
    tick();
    n_cmp++; if (owner !== 1'b0 || mem_addr !== AW'(4)) begin n_fail++; $display("FAIL tie_first: got owner=%b addr=%h want 0 4", owner, mem_addr); end
    tick(); tick();
    n_cmp++; if (cpu_ready !== 1'b1 || upg_ack !== 1'b0) begin n_fail++; $display("FAIL tie_c3: got rdy=%b ack=%b want 1 0", cpu_ready, upg_ack); end
    n_cmp++; if (cpu_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL tie_cpu_rdata: got %h want cafef00d", cpu_rdata); end
    cpu_req = 1'b0;
    tick();
    n_cmp++; if (owner !== 1'b1 || mem_addr !== AW'(7)) begin n_fail++; $display("FAIL tie_second: got owner=%b addr=%h want 1 7", owner, mem_addr); end
    tick();
    n_cmp++; if (upg_ack !== 1'b0) begin n_fail++; $display("FAIL tie_ack_c5: got %b want 0", upg_ack); end
    tick();
    n_cmp++; if (upg_ack !== 1'b1 || upg_rdata !== v) begin n_fail++; $display("FAIL tie_c6: got ack=%b rd=%h want 1 %h", upg_ack, upg_rdata, v); end
    upg_req = 1'b0;
    tick();
  endtask

  task automatic test_reject();
    logic [31:0] addrs [4];
    logic seen_we;
    addrs[0] = 32'h0001_0000; addrs[1] = 32'h0000_0006;
    addrs[2] = {16'($urandom_range(1, 65535)), 16'h0040};
    addrs[3] = {30'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
    for (int k = 0; k < 4; k++) begin
      cpu_we = k[0]; cpu_addr = addrs[k]; cpu_wdata = $urandom; cpu_req = 1'b1; seen_we = 1'b0;
      for (int c = 0; c < 3; c++) begin tick(); seen_we |= mem_we; end
      n_cmp++; if (seen_we !== 1'b0) begin n_fail++; $display("FAIL reject_we[%0d]: got %b want 0", k, seen_we); end
      n_cmp++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b1) begin n_fail++; $display("FAIL reject_c3[%0d]: got rdy=%b err=%b want 1 1", k, cpu_ready, cpu_err); end
      n_cmp++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL reject_rdata[%0d]: got %h want 0", k, cpu_rdata); end
      cpu_req = 1'b0;
      tick();
      n_cmp++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL reject_err_c4[%0d]: got %b want 0", k, cpu_err); end
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] ua [4];
    logic [31:0] ud [4];
    logic [31:0] rd;
    logic last, have_last, prev_we, er;
    int cyc, ucnt, ccnt, t0, lat;
    for (int i = 0; i < 4; i++) begin ua[i] = AW'(20 + 3 * i); ud[i] = $urandom; end
    upg_we = 1'b1; upg_addr = ua[0]; upg_wdata = ud[0]; upg_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
    cyc = 0; ucnt = 0; ccnt = 0; t0 = 0; last = 1'b0; have_last = 1'b0; prev_we = 1'b0;
    while ((ucnt < 4 || cpu_req) && cyc < 80) begin
      tick(); cyc++;
      n_cmp++; if (prev_we && mem_we) begin n_fail++; $display("FAIL stream_we_gap: got two writes in a row at cycle %0d", cyc); end
      prev_we = mem_we;
      if (upg_ack) begin
        n_cmp++; if (have_last && last) begin n_fail++; $display("FAIL stream_alt_upg: got upg twice in a row want alternation at cycle %0d", cyc); end
        last = 1'b1; have_last = 1'b1; ucnt++;
        if (ucnt < 4) begin upg_addr = ua[ucnt]; upg_wdata = ud[ucnt]; end else upg_req = 1'b0;
      end
      if (cpu_req && cpu_ready) begin
        n_cmp++; if (have_last && !last) begin n_fail++; $display("FAIL stream_alt_cpu: got cpu twice in a row want alternation at cycle %0d", cyc); end
        n_cmp++; if (cyc - t0 > 6) begin n_fail++; $display("FAIL stream_cpu_wait: got %0d want <=6", cyc - t0); end
        last = 1'b0; have_last = 1'b1; ccnt++; cpu_req = 1'b0;
      end else if (!cpu_req && ucnt < 4) begin
        cpu_req = 1'b1; t0 = cyc;
      end
    end
    n_cmp++; if (ucnt !== 4 || ccnt < 3) begin n_fail++; $display("FAIL stream_done: got upg=%0d cpu=%0d want 4 >=3", ucnt, ccnt); end
    upg_req = 1'b0; cpu_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b0, 32'(ua[i]) << 2, 32'h0, rd, er, lat);
      n_cmp++; if (rd !== ud[i] || er !== 1'b0) begin n_fail++; $display("FAIL stream_readback[%0d]: got %h err=%b want %h 0", i, rd, er, ud[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v, rd;
    logic er, seen;
    int lat;
    cpu_we = 1'b1; cpu_addr = 32'h0000_0008; cpu_wdata = 32'hA5A5_5A5A; cpu_req = 1'b1;
    tick();
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue: got %b want 1", mem_we); end
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0 || owner !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_state: got addr=%h wd=%h owner=%b want 0 0 1", mem_addr, mem_wdata, owner); end
    n_cmp++; if (cpu_rdata !== '0 || upg_rdata !== '0 || cpu_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_rdata: got cpu=%h upg=%h err=%b want 0 0 0", cpu_rdata, upg_rdata, cpu_err); end
    n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_stall: got %b want 1", cpu_stall); end
    cpu_req = 1'b0; seen = 1'b0;
    for (int c = 0; c < 2; c++) begin tick(); seen |= cpu_ready | upg_ack | mem_we; end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin tick(); seen |= cpu_ready | upg_ack | mem_we; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got activity=%b want 0", seen); end
    v = $urandom;
    preload(AW'(9), v);
    cpu_op(1'b0, 32'h0000_0024, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== v || er !== 1'b0 || lat !== 3) begin
      n_fail++; $display("FAIL rstmid_after: got rd=%h err=%b lat=%0d want %h 0 3", rd, er, lat, v); end
  endtask

  task automatic test_random();
    logic cp, up, cdone, udone, pwe, valid;
    logic [3:0] wa;
    int ct, ut, r, ix;
    for (int i = 0; i < 16; i++) begin shadow[i] = $urandom; preload(AW'(i), shadow[i]); end
    cp = 1'b0; up = 1'b0; pwe = 1'b0; ct = 0; ut = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      cdone = 1'b0; udone = 1'b0;
      n_cmp++; if (pwe && mem_we) begin n_fail++; $display("FAIL rnd_we_gap: got two writes in a row at cycle %0d", cyc); end
      pwe = mem_we;
      n_cmp++; if ((cpu_ready && !cp) || (upg_ack && !up)) begin
        n_fail++; $display("FAIL rnd_spurious: got rdy=%b ack=%b with no request at cycle %0d", cpu_ready, upg_ack, cyc); end
      if (cp && cpu_ready) begin
        valid = (cpu_addr[1:0] == 2'b00) && (cpu_addr[31:AW+2] == '0);
        n_cmp++; if (cpu_err !== !valid) begin n_fail++; $display("FAIL rnd_cpu_err: got %b want %b addr=%h", cpu_err, !valid, cpu_addr); end
        if (!valid) begin
          n_cmp++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL rnd_cpu_rej_rdata: got %h want 0", cpu_rdata); end
        end else begin
          ix = int'(cpu_addr[5:2]);
          if (cpu_we) shadow[ix] = cpu_wdata;
          else begin
            n_cmp++; if (cpu_rdata !== shadow[ix]) begin n_fail++; $display("FAIL rnd_cpu_rdata: got %h want %h word %0d", cpu_rdata, shadow[ix], ix); end
          end
        end
        n_cmp++; if (cyc - ct < 3 || cyc - ct > 6) begin n_fail++; $display("FAIL rnd_cpu_lat: got %0d want 3..6", cyc - ct); end
        cp = 1'b0; cpu_req = 1'b0; cdone = 1'b1;
      end else if (cp && cyc - ct > 20) begin
        n_cmp++; n_fail++; $display("FAIL rnd_cpu_timeout: got no cpu_ready after %0d cycles want <=6", cyc - ct);
        cp = 1'b0; cpu_req = 1'b0; cdone = 1'b1;
      end
      if (up && upg_ack) begin
        ix = int'(upg_addr);
        if (upg_we) shadow[ix] = upg_wdata;
        else begin
          n_cmp++; if (upg_rdata !== shadow[ix]) begin n_fail++; $display("FAIL rnd_upg_rdata: got %h want %h word %0d", upg_rdata, shadow[ix], ix); end
        end
        n_cmp++; if (cyc - ut < 3 || cyc - ut > 6) begin n_fail++; $display("FAIL rnd_upg_lat: got %0d want 3..6", cyc - ut); end
        up = 1'b0; upg_req = 1'b0; udone = 1'b1;
      end else if (up && cyc - ut > 20) begin
        n_cmp++; n_fail++; $display("FAIL rnd_upg_timeout: got no upg_ack after %0d cycles want <=6", cyc - ut);
        up = 1'b0; upg_req = 1'b0; udone = 1'b1;
      end
      if (!cp && !cdone && $urandom_range(0, 2) != 0) begin
        wa = 4'($urandom_range(0, 15)); r = $urandom_range(0, 7);
        cpu_addr = {26'h0, wa, 2'b00};
        if (r == 0) cpu_addr[31:16] = 16'($urandom_range(1, 65535));
        else if (r == 1) cpu_addr[1:0] = 2'($urandom_range(1, 3));
        cpu_we = 1'($urandom_range(0, 1)); cpu_wdata = $urandom;
        cpu_req = 1'b1; cp = 1'b1; ct = cyc;
      end
      if (!up && !udone && $urandom_range(0, 2) != 0) begin
        upg_addr = AW'($urandom_range(0, 15)); upg_we = 1'($urandom_range(0, 1)); upg_wdata = $urandom;
        upg_req = 1'b1; up = 1'b1; ut = cyc;
      end
    end
    cpu_req = 1'b0; upg_req = 1'b0;
    for (int c = 0; c < 8; c++) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    upg_req = 1'b0; upg_we = 1'b0; upg_addr = '0; upg_wdata = '0;
    test_reset();
    test_cpu_load();
    test_cpu_store();
    test_tie();
    test_reject();
    test_stream();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
